// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_seq
//  Purpose  : Time-multiplexed FIR multiply-accumulate stage. It keeps a
//             TAPS-deep sample history and a writable coefficient bank. One
//             multiplier iterates over all taps for every accepted sample,
//             then the result is rounded, saturated and offered downstream.
//  Revision : 1.0  initial release
// ============================================================================
module fir_mac_seq #(
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int TAPS  = 8,
   parameter int AW    = 3,
   parameter int OW    = 16,
   parameter int SHIFT = 15
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [CW-1:0] coef_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data
);

   // Accumulator is wide enough for TAPS full-precision products.
   localparam int ACC_W  = DW + CW + AW;
   localparam int PROD_W = DW + CW;

   // One extra bit on the rounding path keeps the half-LSB add from wrapping.
   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (SHIFT-1);
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((2**(OW-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;

   // LOAD is the output-register cycle between the last MAC edge and OUT.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_LOAD = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic signed [DW-1:0]      r_x [TAPS];
   logic signed [CW-1:0]      w_c [TAPS];
   logic signed [ACC_W-1:0]   r_acc;
   logic [AW-1:0]             r_idx;
   logic [OW-1:0]             r_out;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W:0]     w_rnd;
   logic signed [ACC_W:0]     w_shr;
   logic [OW-1:0]             w_sat;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_coef_en;

   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_last    = (r_idx == AW'(TAPS-1));
   assign w_coef_en = (r_state == S_IDLE) && coef_we;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign out_data  = r_out;

   // State register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: accept, iterate taps, register result, wait for sink.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid)  w_state_nxt = S_MAC;
         S_MAC:  if (w_last)    w_state_nxt = S_LOAD;
         S_LOAD:                w_state_nxt = S_OUT;
         S_OUT:  if (out_ready) w_state_nxt = S_IDLE;
         default:               w_state_nxt = S_IDLE;
      endcase
   end

   // Sample history: shift in a new sample each time one is accepted.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      end else if (w_accept) begin
         r_x[0] <= $signed(in_data);
         for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
      end
   end

   // Coefficient bank: one register per tap, out-of-range addresses match none.
   for (genvar g = 0; g < TAPS; g++) begin : g_coef
      logic signed [CW-1:0] r_coef;

      // Write only while idle so a running MAC sees a stable bank.
      always_ff @(posedge CLK or negedge rst_n) begin
         if (!rst_n) begin
            r_coef <= '0;
         end else if (w_coef_en && (coef_addr == AW'(g))) begin
            r_coef <= $signed(coef_data);
         end
      end

      assign w_c[g] = r_coef;
   end

   // Single shared multiplier, full-precision signed product.
   assign w_prod = r_x[r_idx] * w_c[r_idx];

   // Round half up, arithmetic shift, then clamp to the output range.
   always_comb begin
      w_rnd = {r_acc[ACC_W-1], r_acc} + RND_HALF;
      w_shr = w_rnd >>> SHIFT;
      w_sat = w_shr[OW-1:0];
      if (w_shr > SAT_MAX) begin
         w_sat = SAT_MAX[OW-1:0];
      end else if (w_shr < SAT_MIN) begin
         w_sat = SAT_MIN[OW-1:0];
      end
   end

   // Accumulator, tap index and output register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_idx <= '0;
         r_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_acc <= '0;
                  r_idx <= '0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + ACC_W'(w_prod);
               r_idx <= r_idx + 1'b1;
            end
            S_LOAD: begin
               r_out <= w_sat;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_seq
//  Purpose  : Directed bench for fir_mac_seq with a queue-based scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_mac_seq;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        coef_we;
   logic [2:0]  coef_addr;
   logic [15:0] coef_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   int checks = 0;
   int errors = 0;
   logic signed [15:0] exp_q[$];

   fir_mac_seq dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 CLK = ~CLK;

   // Scoreboard monitor: compare each delivered output with the queue head.
   always @(negedge CLK) begin
      logic signed [15:0] e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %0d required none", $signed(out_data));
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data got %0d required %0d", $signed(out_data), e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge CLK);
      #1 rst_n = 1'b1;
   endtask

   task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(posedge CLK); #1;
      coef_we = 1'b0;
   endtask

   // Present one sample; returns one ns after the accepting edge.
   task automatic launch(input logic signed [15:0] d, input bit push, input logic signed [15:0] e);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge CLK); #1; n++;
      end
      if (n >= 50) check("launch_timeout", 1, 0);
      in_valid = 1'b1; in_data = d;
      if (push) exp_q.push_back(e);
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   // Wait until every queued expectation has been consumed.
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge CLK); #1; n++;
      end
      if (n >= 60) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic send(input logic signed [15:0] d, input logic signed [15:0] e);
      launch(d, 1'b1, e);
      drain();
   endtask

   initial begin
      int n;
      in_valid = 0; in_data = 0; coef_we = 0; coef_addr = 0; coef_data = 0; out_ready = 1;
      rst_n = 1'b0;

      // Reset with random stimulus on every input.
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         in_valid = 1'($urandom); in_data = 16'($urandom); coef_we = 1'($urandom);
         coef_addr = 3'($urandom); coef_data = 16'($urandom); out_ready = 1'($urandom);
      end
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      in_valid = 0; coef_we = 0; out_ready = 1;
      rst_n = 1'b1;
      @(posedge CLK); #1;

      // Zero coefficients, check latency: valid first after edge k+9.
      launch(16'sd100, 1'b1, 16'sd0);
      for (int i = 1; i <= 9; i++) begin
         @(posedge CLK); #1;
         check("latency_out_valid", int'(out_valid), (i == 9) ? 1 : 0);
      end
      drain();

      // Impulse response.
      do_reset();
      wr_coef(3'd0, 16'h4000);
      wr_coef(3'd1, 16'h2000);
      send(16'sd16384, 16'sd8192);
      send(16'sd0, 16'sd4096);
      send(16'sd0, 16'sd0);

      // Positive saturation, then negative saturation.
      do_reset();
      for (int i = 0; i < 8; i++) wr_coef(3'(i), 16'h7FFF);
      send(16'sd32767, 16'sd32766);
      for (int i = 1; i < 8; i++) send(16'sd32767, 16'sd32767);
      for (int i = 0; i < 8; i++) wr_coef(3'(i), 16'h8000);
      for (int i = 0; i < 8; i++) send(16'sd32767, -16'sd32768);

      // Rounding at the half-LSB boundary.
      do_reset();
      wr_coef(3'd0, 16'h0001);
      send(16'sd16384, 16'sd1);
      send(16'sd16383, 16'sd0);
      send(-16'sd16384, 16'sd0);

      // Backpressure: output held, in_valid pulses dropped.
      do_reset();
      wr_coef(3'd0, 16'h4000);
      wr_coef(3'd1, 16'h2000);
      out_ready = 1'b0;
      launch(16'sd16384, 1'b1, 16'sd8192);
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin
         @(posedge CLK); #1; n++;
      end
      check("bp_out_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'sd1000;
         check("bp_out_data", int'($signed(out_data)), 8192);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Coefficient write during MAC is ignored: old c[0] must be used.
      launch(16'sd16384, 1'b1, 16'sd12288);
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF;
      @(posedge CLK); #1;
      coef_we = 1'b0;
      drain();

      // Reset during MAC cycle 3 aborts the computation.
      launch(16'sd5000, 1'b0, 16'sd0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_out_data", int'(out_data), 0);
      repeat (2) @(posedge CLK);
      #1 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge CLK); #1;
         if (out_valid === 1'b1) n++;
      end
      check("abort_no_output", n, 0);
      wr_coef(3'd0, 16'h4000);
      send(16'sd16384, 16'sd8192);

      repeat (3) @(posedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
